// File: rtl/instr_fetch_server_pkg.sv
// Shared types and defaults for the instruction fetch server.
`default_nettype none
package instr_fetch_server_pkg;

  typedef enum logic [1:0] {
    ST_PROGRAM = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2
  } ifs_state_e;

  localparam int          IFS_ADDR_W    = 7;
  localparam logic [31:0] IFS_NOP_INSTR = 32'hE1A00000;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_server_imem_array.sv
// Instruction storage: one write port, one registered read port, contents never reset.
`default_nettype none
module imem_array #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_server.sv
// Program-load FSM plus two-stage fetch pipeline (F1 address, F2 memory read) feeding decode.
`default_nettype none
module instr_fetch_server
  import instr_fetch_server_pkg::*;
#(
  parameter int          ADDR_W    = IFS_ADDR_W,
  parameter logic [31:0] NOP_INSTR = IFS_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  input  logic              prog_last,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic              halt,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              cpu_rst_n
);

  ifs_state_e        state;
  logic              f1_valid;
  logic [ADDR_W-1:0] f1_addr;
  logic              f2_valid;
  logic [ADDR_W-1:0] f2_addr;
  logic [31:0]       rd_data;
  logic              mem_we;

  assign mem_we = (state == ST_PROGRAM) && prog_valid && prog_ready;

  // Read address is F1, so the read data lines up with F2 one edge later.
  imem_array #(.ADDR_W(ADDR_W)) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (f1_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_PROGRAM;
      prog_ready  <= 1'b0;
      cpu_rst_n   <= 1'b0;
      f1_valid    <= 1'b0;
      f1_addr     <= '0;
      f2_valid    <= 1'b0;
      f2_addr     <= '0;
      instr_out   <= NOP_INSTR;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      f1_valid    <= 1'b0;
      f2_valid    <= f1_valid;
      f2_addr     <= f1_addr;
      instr_valid <= f2_valid;
      instr_out   <= f2_valid ? rd_data : NOP_INSTR;
      instr_pc    <= f2_valid ? f2_addr : '0;
      case (state)
        ST_PROGRAM: begin
          prog_ready <= 1'b1;
          if (prog_valid && prog_ready && prog_last) begin
            state      <= ST_RUN;
            prog_ready <= 1'b0;
            cpu_rst_n  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (halt) begin
            state       <= ST_HALTED;
            cpu_rst_n   <= 1'b0;
            f2_valid    <= 1'b0;
            instr_valid <= 1'b0;
            instr_out   <= NOP_INSTR;
            instr_pc    <= '0;
          end else begin
            if (fetch_en) begin
              f1_valid <= 1'b1;
              f1_addr  <= fetch_addr;
            end
            // A same-edge fetch survives the flush: it is the branch target.
            if (flush) begin
              f2_valid    <= 1'b0;
              instr_valid <= 1'b0;
              instr_out   <= NOP_INSTR;
              instr_pc    <= '0;
            end
          end
        end
        ST_HALTED: begin
          if (prog_valid) begin
            state      <= ST_PROGRAM;
            prog_ready <= 1'b1;
          end
        end
        default: begin
          state      <= ST_PROGRAM;
          prog_ready <= 1'b0;
          cpu_rst_n  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_server.sv
// Directed self-checking bench for instr_fetch_server.
`default_nettype none
module tb_instr_fetch_server;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk;
  logic        rst_n;
  logic        prog_valid;
  logic        prog_ready;
  logic [6:0]  prog_addr;
  logic [31:0] prog_data;
  logic        prog_last;
  logic [6:0]  fetch_addr;
  logic        fetch_en;
  logic        flush;
  logic        halt;
  logic [31:0] instr_out;
  logic [6:0]  instr_pc;
  logic        instr_valid;
  logic        cpu_rst_n;

  int checks   = 0;
  int failures = 0;

  instr_fetch_server dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_valid  (prog_valid),
    .prog_ready  (prog_ready),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_last   (prog_last),
    .fetch_addr  (fetch_addr),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .halt        (halt),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .cpu_rst_n   (cpu_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [6:0] a, input logic [31:0] d, input logic last);
    prog_valid = 1'b1;
    prog_addr  = a;
    prog_data  = d;
    prog_last  = last;
    step();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  task automatic fetch(input logic en, input logic [6:0] a);
    fetch_en   = en;
    fetch_addr = a;
    step();
  endtask

  task automatic chk_out(input string tag, input logic [31:0] d, input logic [6:0] pc, input logic v);
    chk({tag, "_data"}, instr_out, d);
    if (v) chk({tag, "_pc"}, 32'(instr_pc), 32'(pc));
    chk({tag, "_valid"}, 32'(instr_valid), 32'(v));
  endtask

  initial begin
    rst_n = 1'b0; prog_valid = 1'b0; prog_addr = '0; prog_data = '0; prog_last = 1'b0;
    fetch_addr = '0; fetch_en = 1'b0; flush = 1'b0; halt = 1'b0;
    #12;
    chk("rst_prog_ready", 32'(prog_ready), 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk_out("rst_out", NOP, 7'd0, 1'b0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(prog_ready), 32'd1);

    // Program mem[127] then words 0..3, last on word 3.
    prog(7'd127, 32'hDEADBEEF, 1'b0);
    prog(7'd0, 32'h11111111, 1'b0);
    prog(7'd1, 32'h22222222, 1'b0);
    prog(7'd2, 32'h33333333, 1'b0);
    chk("cpu_rst_before_last", 32'(cpu_rst_n), 32'd0);
    prog(7'd3, 32'h44444444, 1'b1);
    chk("cpu_rst_after_last", 32'(cpu_rst_n), 32'd1);
    chk("ready_in_run", 32'(prog_ready), 32'd0);

    // Back-to-back fetches, latency 2.
    fetch(1'b1, 7'd0);
    fetch(1'b1, 7'd1);
    fetch(1'b1, 7'd2);
    chk_out("f0", 32'h11111111, 7'd0, 1'b1);
    fetch(1'b0, 7'd0);
    chk_out("f1", 32'h22222222, 7'd1, 1'b1);
    step();
    chk_out("f2", 32'h33333333, 7'd2, 1'b1);
    step();
    chk_out("bubble", NOP, 7'd0, 1'b0);

    // Flush with same-edge branch target 0.
    fetch(1'b1, 7'd1);
    fetch(1'b1, 7'd2);
    flush = 1'b1;
    fetch(1'b1, 7'd0);
    flush = 1'b0;
    chk_out("flush_k0", NOP, 7'd0, 1'b0);
    fetch(1'b0, 7'd0);
    chk_out("flush_k1", NOP, 7'd0, 1'b0);
    step();
    chk_out("flush_tgt", 32'h11111111, 7'd0, 1'b1);

    // Top address and wrap back to 0.
    fetch(1'b1, 7'd127);
    fetch(1'b1, 7'd0);
    fetch(1'b0, 7'd0);
    chk_out("addr127", 32'hDEADBEEF, 7'd127, 1'b1);
    step();
    chk_out("wrap0", 32'h11111111, 7'd0, 1'b1);

    // Halt mid-stream.
    fetch(1'b1, 7'd1);
    fetch(1'b1, 7'd2);
    halt = 1'b1;
    fetch(1'b1, 7'd3);
    halt = 1'b0;
    chk_out("halt_out", NOP, 7'd0, 1'b0);
    chk("halt_cpu_rst", 32'(cpu_rst_n), 32'd0);
    fetch(1'b1, 7'd0);
    fetch(1'b1, 7'd1);
    fetch(1'b0, 7'd0);
    chk_out("halted_ignore", NOP, 7'd0, 1'b0);
    chk("halted_ready", 32'(prog_ready), 32'd0);
    // This word must be dropped; mem[1] keeps 22222222.
    prog(7'd1, 32'hBADBAD01, 1'b0);
    chk("reprog_ready", 32'(prog_ready), 32'd1);
    prog(7'd4, 32'h55555555, 1'b1);
    chk("rerun_cpu_rst", 32'(cpu_rst_n), 32'd1);

    fetch(1'b1, 7'd1);
    fetch(1'b1, 7'd4);
    fetch(1'b0, 7'd0);
    chk_out("halt_word_dropped", 32'h22222222, 7'd1, 1'b1);
    fetch(1'b1, 7'd0);
    chk_out("pre_rst", 32'h55555555, 7'd4, 1'b1);

    // Asynchronous reset between fetches.
    fetch_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", NOP, 7'd0, 1'b0);
    chk("async_rst_cpu", 32'(cpu_rst_n), 32'd0);
    chk("async_rst_ready", 32'(prog_ready), 32'd0);
    #2 rst_n = 1'b1;
    step();
    chk("rst2_ready", 32'(prog_ready), 32'd1);
    prog(7'd5, 32'h66666666, 1'b1);
    chk("rst2_cpu_rst", 32'(cpu_rst_n), 32'd1);
    fetch(1'b1, 7'd0);
    fetch(1'b1, 7'd5);
    fetch(1'b0, 7'd0);
    chk_out("mem_kept", 32'h11111111, 7'd0, 1'b1);
    step();
    chk_out("reload5", 32'h66666666, 7'd5, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
